// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: FSM encoding,
// ALU op codes and default iteration counts.
package multdiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [4:0] ALU_MULT = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    localparam int DEF_MUL_STEPS = 16;
    localparam int DEF_DIV_STEPS = 32;

    // Booth radix-4 window: {b[2i+1], b[2i], b[2i-1]}
    typedef logic [2:0] booth_sel_t;

endpackage

// File: rtl/booth_r4_sel.sv
// Radix-4 Booth digit selector: maps a 3-bit multiplier window to a partial
// product magnitude (0, M or 2M, sign-extended) plus a subtract flag.
module booth_r4_sel
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH+1:0] pp,
    output logic             neg
);

    booth_sel_t       sel_w;
    logic [WIDTH+1:0] m_x1;
    logic [WIDTH+1:0] m_x2;

    assign sel_w = sel;
    assign m_x1  = {{2{m[WIDTH-1]}}, m};
    assign m_x2  = {m[WIDTH-1], m, 1'b0};

    // Negative digits are returned as magnitudes; the caller's adder subtracts.
    always_comb begin
        pp  = '0;
        neg = 1'b0;
        case (sel_w)
            3'b001, 3'b010: pp = m_x1;
            3'b011:         pp = m_x2;
            3'b100: begin
                pp  = m_x2;
                neg = 1'b1;
            end
            3'b101, 3'b110: begin
                pp  = m_x1;
                neg = 1'b1;
            end
            default: begin
                pp  = '0;
                neg = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-4 Booth) / divide (non-restoring) unit
// answering the X-stage start pulse with a one-cycle result-ready pulse.
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MUL_STEPS = DEF_MUL_STEPS,
    parameter int DIV_STEPS = DEF_DIV_STEPS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    // One guard bit beyond sign+magnitude keeps the Booth running sum and the
    // shifted non-restoring remainder exact.
    localparam int AW = WIDTH + 2;
    localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_reg, state_next;
    logic [5:0]       count_reg;
    logic [AW-1:0]    hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic [WIDTH-1:0] opnd_reg;
    logic             prev_reg;
    logic             neg_q_reg;
    logic             div_zero_reg;
    logic             div_ovf_reg;

    logic [AW-1:0]    pp;
    logic             pp_neg;
    logic [AW-1:0]    add_a, add_b, add_sum;
    logic             add_sub;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [2*WIDTH-1:0] product;
    logic             mul_exc;
    logic [WIDTH-1:0] quot;
    logic             finishing;

    booth_r4_sel #(.WIDTH(WIDTH)) u_sel (
        .sel (booth_sel_t'({lo_reg[1:0], prev_reg})),
        .m   (opnd_reg),
        .pp  (pp),
        .neg (pp_neg)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (ctrl_MULT) begin
            state_next = ST_MUL;
        end else if (ctrl_DIV) begin
            state_next = ST_DIV;
        end else begin
            case (state_reg)
                ST_MUL, ST_DIV: if (count_reg == 6'd0) state_next = ST_DONE;
                ST_DONE:        state_next = ST_IDLE;
                default:        state_next = state_reg;
            endcase
        end
    end

    // Shared adder/subtractor: Booth accumulate in MUL, remainder step in DIV.
    always_comb begin
        add_a   = hi_reg;
        add_b   = pp;
        add_sub = pp_neg;
        if (state_reg == ST_DIV) begin
            add_a   = {hi_reg[AW-2:0], lo_reg[WIDTH-1]};
            add_b   = {2'b00, opnd_reg};
            add_sub = ~hi_reg[AW-1];
        end
    end

    assign add_sum = add_a + (add_b ^ {AW{add_sub}}) + AW'(add_sub);

    assign a_mag = data_operandA[WIDTH-1] ? (~data_operandA + WIDTH'(1)) : data_operandA;
    assign b_mag = data_operandB[WIDTH-1] ? (~data_operandB + WIDTH'(1)) : data_operandB;

    assign product   = {hi_reg[WIDTH-1:0], lo_reg};
    assign mul_exc   = product[2*WIDTH-1:WIDTH] != {WIDTH{product[WIDTH-1]}};
    assign quot      = neg_q_reg ? (~lo_reg + WIDTH'(1)) : lo_reg;
    assign finishing = (state_reg == ST_MUL || state_reg == ST_DIV) && count_reg == 6'd0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_reg      <= '0;
            hi_reg         <= '0;
            lo_reg         <= '0;
            opnd_reg       <= '0;
            prev_reg       <= 1'b0;
            neg_q_reg      <= 1'b0;
            div_zero_reg   <= 1'b0;
            div_ovf_reg    <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (ctrl_MULT) begin
            hi_reg    <= '0;
            lo_reg    <= data_operandB;
            opnd_reg  <= data_operandA;
            prev_reg  <= 1'b0;
            count_reg <= 6'(MUL_STEPS);
        end else if (ctrl_DIV) begin
            hi_reg       <= '0;
            lo_reg       <= a_mag;
            opnd_reg     <= b_mag;
            prev_reg     <= 1'b0;
            neg_q_reg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div_zero_reg <= (data_operandB == '0);
            div_ovf_reg  <= (data_operandA == INT_MIN) && (data_operandB == '1);
            count_reg    <= 6'(DIV_STEPS);
        end else if (finishing) begin
            if (state_reg == ST_MUL) begin
                data_result    <= product[WIDTH-1:0];
                data_exception <= mul_exc;
            end else begin
                data_result    <= div_zero_reg ? '0 : quot;
                data_exception <= div_zero_reg | div_ovf_reg;
            end
        end else if (state_reg == ST_MUL) begin
            // Arithmetic shift of {sum, lo} right by two consumes one Booth digit.
            hi_reg    <= {{2{add_sum[AW-1]}}, add_sum[AW-1:2]};
            lo_reg    <= {add_sum[1:0], lo_reg[WIDTH-1:2]};
            prev_reg  <= lo_reg[1];
            count_reg <= count_reg - 6'd1;
        end else if (state_reg == ST_DIV) begin
            hi_reg    <= add_sum;
            lo_reg    <= {lo_reg[WIDTH-2:0], ~add_sum[AW-1]};
            count_reg <= count_reg - 6'd1;
        end
    end

    assign data_resultRDY = (state_reg == ST_DONE);

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed corner cases, abort and reset
// scenarios, then randomized operations against an arithmetic reference model.
module tb_multdiv_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int checks = 0;
    int errors = 0;

    multdiv_unit dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic ref_model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] r, output logic e);
        longint p;
        int sa, sb;
        if (!is_div) begin
            p = longint'($signed(a)) * longint'($signed(b));
            r = p[31:0];
            e = (p != longint'($signed(p[31:0])));
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            sa = $signed(a);
            sb = $signed(b);
            r  = 32'(sa / sb);
            e  = 1'b0;
        end
    endtask

    task automatic start_op(input bit mul, input bit div, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = mul;
        ctrl_DIV      = div;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        // Operands are don't-care after the start edge.
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_result(input string tag, input int exp_lat,
                               input logic [31:0] exp_r, input logic exp_e);
        int k = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                k = i;
                break;
            end
        end
        $display("OP %s lat=%0d res=%h exc=%0b exp_res=%h exp_exc=%0b",
                 tag, k, data_result, data_exception, exp_r, exp_e);
        check_val({tag, "_lat"}, 32'(k), 32'(exp_lat));
        check_val({tag, "_res"}, data_result, exp_r);
        check_val({tag, "_exc"}, 32'(data_exception), 32'(exp_e));
        @(posedge clock);
        #1;
        check_val({tag, "_pulse"}, 32'(data_resultRDY), 32'd0);
    endtask

    task automatic do_op(input string tag, input bit mul, input bit div,
                         input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        e;
        ref_model(!mul, a, b, r, e);
        start_op(mul, div, a, b);
        wait_result(tag, mul ? 17 : 33, r, e);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 9))
            0: v = 32'd0;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'h8000_0000;
            3: v = 32'h7FFF_FFFF;
            4: v = $urandom_range(0, 100);
            5: v = -$urandom_range(0, 100);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        int rdy_count;
        logic [31:0] ra, rb;
        bit is_mul;

        repeat (3) @(posedge clock);
        #1;
        check_val("reset_rdy", 32'(data_resultRDY), 32'd0);
        check_val("reset_res", data_result, 32'd0);
        check_val("reset_exc", 32'(data_exception), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        do_op("mul_7x-3", 1'b1, 1'b0, 32'd7, -32'd3);
        do_op("mul_ovf", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
        do_op("div_-7/2", 1'b0, 1'b1, -32'd7, 32'd2);
        do_op("div_100/7", 1'b0, 1'b1, 32'd100, 32'd7);
        do_op("div_5/0", 1'b0, 1'b1, 32'd5, 32'd0);
        do_op("div_min/-1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("both_6x4", 1'b1, 1'b1, 32'd6, 32'd4);
        do_op("mul_minxmin", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);

        // Divide pulse in cycle 5 of a multiply aborts it.
        start_op(1'b1, 1'b0, 32'd123, 32'd456);
        repeat (4) @(posedge clock);
        start_op(1'b0, 1'b1, 32'd9, 32'd3);
        wait_result("abort_div", 33, 32'd3, 1'b0);

        // Reset mid-divide clears outputs at once and discards the operation.
        start_op(1'b0, 1'b1, 32'd1000, 32'd7);
        repeat (9) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_val("rst_mid_rdy", 32'(data_resultRDY), 32'd0);
        check_val("rst_mid_res", data_result, 32'd0);
        check_val("rst_mid_exc", 32'(data_exception), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        rdy_count = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) rdy_count++;
        end
        check_val("rst_no_rdy", 32'(rdy_count), 32'd0);

        for (int n = 0; n < 40; n++) begin
            is_mul = $urandom_range(0, 1) == 1;
            ra = pick_operand();
            rb = pick_operand();
            do_op(is_mul ? "rnd_mul" : "rnd_div", is_mul, !is_mul, ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
